idc_mod2_tx: RTL

//  Bit-true digital model of the 2nd-order incremental delta-sigma modulator (IDC front end)

---
 rtl/idc_mod2_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/idc_mod2_tx.sv
// Second-order incremental delta-sigma modulator producing 2*M-1 bits per conversion.
// Optional integrator saturation with sticky overflow flag: define IDC_MOD_SAT_EN.
module idc_mod2_tx #(
  parameter int unsigned W  = 16,
  parameter int unsigned IW = W + 4
) (
  input  logic                clk_state,
  input  logic                rstb_raw,
  input  logic                start,
  input  logic signed [W-1:0] x_in,
  input  logic [9:0]          M_in,
  output logic                ready,
  output logic                busy,
  output logic                filt_rst,
  output logic                d_out,
  output logic                bit_valid,
  output logic                done,
  output logic                ovf
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StClr  = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic signed [IW-1:0] LpFs = {{(IW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

  logic [1:0]           r_state, w_state_nxt;
  logic signed [W-1:0]  r_x;
  logic [9:0]           r_m, r_cnt, w_m_eff;
  logic signed [IW-1:0] r_u1, r_u2;
  logic signed [IW-1:0] w_u1_op, w_u2_op, w_x_ext, w_fb, w_e, w_u1_nxt, w_u2_nxt;
  logic                 r_d, r_bv, w_v, w_last, w_step;
  logic [10:0]          w_last_idx;

  always_comb begin
    if (M_in == 10'd0)        w_m_eff = 10'd1;
    else if (M_in > 10'd512)  w_m_eff = 10'd512;
    else                      w_m_eff = M_in;
  end

  assign w_last_idx = {r_m, 1'b0} - 11'd2;
  assign w_last     = ({1'b0, r_cnt} == w_last_idx);

  // The CLR->RUN edge emits bit 0 from cleared integrators; later RUN edges emit the rest.
  assign w_step  = (r_state == StClr) || ((r_state == StRun) && !w_last);
  assign w_u1_op = (r_state == StClr) ? '0 : r_u1;
  assign w_u2_op = (r_state == StClr) ? '0 : r_u2;
  assign w_x_ext = {{(IW-W){r_x[W-1]}}, r_x};
  assign w_v     = ~w_u2_op[IW-1];
  assign w_fb    = w_v ? LpFs : -LpFs;
  assign w_e     = w_x_ext - w_fb;

`ifdef IDC_MOD_SAT_EN
  localparam logic signed [IW+1:0] LpMax = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [IW+1:0] LpMin = -LpMax;

  logic signed [IW+1:0] w_u1_sum, w_u2_sum;
  logic                 w_clamp1, w_clamp2, r_ovf;

  always_comb begin
    w_clamp1 = 1'b0;
    w_clamp2 = 1'b0;
    w_u1_sum = {{2{w_u1_op[IW-1]}}, w_u1_op} + {{2{w_e[IW-1]}}, w_e};
    if (w_u1_sum > LpMax) begin
      w_u1_nxt = LpMax[IW-1:0];
      w_clamp1 = 1'b1;
    end else if (w_u1_sum < LpMin) begin
      w_u1_nxt = LpMin[IW-1:0];
      w_clamp1 = 1'b1;
    end else begin
      w_u1_nxt = w_u1_sum[IW-1:0];
    end
    w_u2_sum = {{2{w_u2_op[IW-1]}}, w_u2_op} + {{2{w_u1_nxt[IW-1]}}, w_u1_nxt}
             - {{2{w_fb[IW-1]}}, w_fb};
    if (w_u2_sum > LpMax) begin
      w_u2_nxt = LpMax[IW-1:0];
      w_clamp2 = 1'b1;
    end else if (w_u2_sum < LpMin) begin
      w_u2_nxt = LpMin[IW-1:0];
      w_clamp2 = 1'b1;
    end else begin
      w_u2_nxt = w_u2_sum[IW-1:0];
    end
  end

  always_ff @(posedge clk_state or negedge rstb_raw) begin
    if (!rstb_raw) begin
      r_ovf <= 1'b0;
    end else if (r_state == StClr) begin
      r_ovf <= 1'b0;
    end else if (w_step && (w_clamp1 || w_clamp2)) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  always_comb begin
    w_u1_nxt = w_u1_op + w_e;
    w_u2_nxt = w_u2_op + w_u1_nxt - w_fb;
  end

  assign ovf = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (start) w_state_nxt = StClr;
      StClr:   w_state_nxt = StRun;
      StRun:   if (w_last) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_state or negedge rstb_raw) begin
    if (!rstb_raw) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_m     <= 10'd1;
      r_cnt   <= '0;
      r_u1    <= '0;
      r_u2    <= '0;
      r_d     <= 1'b0;
      r_bv    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == StIdle) && start) begin
        r_x <= x_in;
        r_m <= w_m_eff;
      end
      if (w_step) begin
        r_u1  <= w_u1_nxt;
        r_u2  <= w_u2_nxt;
        r_d   <= w_v;
        r_bv  <= 1'b1;
        r_cnt <= (r_state == StClr) ? 10'd0 : r_cnt + 10'd1;
      end else if (r_state == StRun) begin
        r_bv <= 1'b0;
      end
    end
  end

  assign ready     = (r_state == StIdle);
  assign busy      = (r_state == StClr) || (r_state == StRun);
  assign filt_rst  = (r_state == StIdle) || (r_state == StClr);
  assign done      = (r_state == StDone);
  assign d_out     = r_d;
  assign bit_valid = r_bv;

endmodule
